// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters, owns the flag register F and supports locked op chains with an idle timeout
module alu_arbiter #(
   parameter logic [3:0] FLAG_RESET   = 4'hB,
   parameter int         LOCK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [7:0]  req0_op,
   input  logic [15:0] req0_x,
   input  logic [15:0] req0_y,
   input  logic [3:0]  req0_fmask,
   input  logic        req0_lock,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [7:0]  req1_op,
   input  logic [15:0] req1_x,
   input  logic [15:0] req1_y,
   input  logic [3:0]  req1_fmask,
   input  logic        req1_lock,
   output logic        rsp0_valid,
   output logic [15:0] rsp0_data,
   output logic [3:0]  rsp0_flags,
   output logic        rsp1_valid,
   output logic [15:0] rsp1_data,
   output logic [3:0]  rsp1_flags,
   output logic [7:0]  alu_op,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic [3:0]  alu_fin,
   input  logic [15:0] alu_o,
   input  logic [3:0]  alu_fout,
   output logic [3:0]  flags,
   input  logic        flags_wr_en,
   input  logic [3:0]  flags_wr_data,
   output logic [1:0]  lock_owner,
   output logic        lock_drop
);
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);
   typedef enum logic [1:0] {UNLOCKED = 2'b00, LOCKED0 = 2'b01, LOCKED1 = 2'b10} lockState_t;
   lockState_t lockState, lockNext;
   logic [CW-1:0] idleCnt, idleNext;
   logic lastGrant, grant0, grant1, accept, acceptLock, dropNow;
   logic issValid, issId;
   logic [7:0] issOp;
   logic [15:0] issX, issY;
   logic [3:0] issMask, fReg;
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      lockNext = lockState;
      idleNext = idleCnt;
      dropNow = 1'b0;
      case (lockState)
         LOCKED0: grant0 = req0_valid;
         LOCKED1: grant1 = req1_valid;
         default: begin
            grant0 = req0_valid && (!req1_valid || lastGrant);
            grant1 = req1_valid && !grant0;
         end
      endcase
      accept = grant0 || grant1;
      acceptLock = grant1 ? req1_lock : req0_lock;
      if (accept) begin
         idleNext = '0;
         if (!acceptLock) lockNext = UNLOCKED;
         else if (grant1) lockNext = LOCKED1;
         else lockNext = LOCKED0;
      end else if (lockState != UNLOCKED) begin
         // owner is idle here, otherwise it would have been granted
         if (idleCnt == CW'(LOCK_TIMEOUT - 1)) begin
            lockNext = UNLOCKED;
            idleNext = '0;
            dropNow = 1'b1;
         end else idleNext = idleCnt + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lockState <= UNLOCKED;
         idleCnt <= '0;
         lastGrant <= 1'b1;
         issValid <= 1'b0;
         issId <= 1'b0;
         issOp <= '0;
         issX <= '0;
         issY <= '0;
         issMask <= '0;
         fReg <= FLAG_RESET;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data <= '0;
         rsp1_data <= '0;
         rsp0_flags <= '0;
         rsp1_flags <= '0;
      end else begin
         lockState <= lockNext;
         idleCnt <= idleNext;
         if (accept) lastGrant <= grant1;
         issValid <= accept;
         issId <= grant1;
         issOp <= accept ? (grant1 ? req1_op : req0_op) : '0;
         issX <= accept ? (grant1 ? req1_x : req0_x) : '0;
         issY <= accept ? (grant1 ? req1_y : req0_y) : '0;
         issMask <= accept ? (grant1 ? req1_fmask : req0_fmask) : '0;
         rsp0_valid <= issValid && !issId;
         rsp1_valid <= issValid && issId;
         if (issValid && !issId) begin
            rsp0_data <= alu_o;
            rsp0_flags <= alu_fout;
         end
         if (issValid && issId) begin
            rsp1_data <= alu_o;
            rsp1_flags <= alu_fout;
         end
         // a direct write wins over the execute-stage merge
         fReg <= flags_wr_en ? flags_wr_data : issValid ? ((fReg & ~issMask) | (alu_fout & issMask)) : fReg;
      end
   end
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign alu_op = issOp;
   assign alu_x = issX;
   assign alu_y = issY;
   assign alu_fin = fReg;
   assign flags = fReg;
   assign lock_owner = lockState;
   assign lock_drop = dropNow;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a behavioural ALU, flag and arbitration model
module tb_alu_arbiter;
   localparam int TO = 16;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req0_valid, req0_ready, req0_lock, req1_valid, req1_ready, req1_lock;
   logic [7:0] req0_op, req1_op, alu_op;
   logic [15:0] req0_x, req0_y, req1_x, req1_y, alu_x, alu_y, alu_o, rsp0_data, rsp1_data;
   logic [3:0] req0_fmask, req1_fmask, alu_fin, alu_fout, rsp0_flags, rsp1_flags, flags, flags_wr_data;
   logic rsp0_valid, rsp1_valid, flags_wr_en, lock_drop;
   logic [1:0] lock_owner;
   int checks = 0, failures = 0;
   typedef struct {logic id; logic [15:0] data; logic [3:0] fl; int due;} rsp_t;
   rsp_t q[$];

   alu_arbiter #(.FLAG_RESET(4'hB), .LOCK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
      .req0_fmask(req0_fmask), .req0_lock(req0_lock),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
      .req1_fmask(req1_fmask), .req1_lock(req1_lock),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
      .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_fin(alu_fin), .alu_o(alu_o), .alu_fout(alu_fout),
      .flags(flags), .flags_wr_en(flags_wr_en), .flags_wr_data(flags_wr_data),
      .lock_owner(lock_owner), .lock_drop(lock_drop));

   always #5 clk = ~clk;

   // toy ALU: op[1:0] selects ADD, fin-dependent adjust, SUB, AND-with-flags-from-y
   function automatic logic [19:0] refAlu(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y, input logic [3:0] fin);
      logic [4:0] h;
      logic [8:0] c;
      logic [15:0] d;
      logic [3:0] f;
      h = {1'b0, x[3:0]} + {1'b0, y[3:0]};
      c = {1'b0, x[7:0]} + {1'b0, y[7:0]};
      case (op[1:0])
         2'd0: begin d = x + y; f = {d[7:0] == 8'h00, 1'b0, h[4], c[8]}; end
         2'd1: begin d = x ^ {12'h000, fin}; f = fin ^ 4'b0101; end
         2'd2: begin d = x - y; f = {d == 16'h0000, 1'b1, x[3:0] < y[3:0], x < y}; end
         default: begin d = x & y; f = y[3:0]; end
      endcase
      return {f, d};
   endfunction

   always_comb {alu_fout, alu_o} = refAlu(alu_op, alu_x, alu_y, alu_fin);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor / reference model, evaluated mid-cycle
   initial begin
      int cyc, mOwner, mIdle;
      logic mLast, pendV, pendId, e0, e1, eDrop, acc0, acc1;
      logic [7:0] pendOp;
      logic [15:0] pendX, pendY;
      logic [3:0] pendM, mF;
      logic [19:0] r;
      rsp_t it;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            mOwner = 0; mIdle = 0; mLast = 1'b1; pendV = 1'b0; mF = 4'hB;
            q.delete();
            chk("rst_flags", flags, 4'hB);
            chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
            chk("rst_owner", lock_owner, 2'b00);
         end else begin
            e0 = (mOwner == 1) ? req0_valid : (mOwner == 2) ? 1'b0 : (req0_valid && (!req1_valid || mLast));
            e1 = (mOwner == 2) ? req1_valid : (mOwner == 1) ? 1'b0 : (req1_valid && !e0);
            eDrop = (mOwner == 1 && !req0_valid || mOwner == 2 && !req1_valid) && mIdle == TO - 1;
            chk("ready0", req0_ready, e0);
            chk("ready1", req1_ready, e1);
            chk("lock_owner", lock_owner, mOwner[1:0]);
            chk("lock_drop", lock_drop, eDrop);
            chk("flags", flags, mF);
            chk("alu_fin", alu_fin, mF);
            chk("alu_issue", {alu_op, alu_x, alu_y}, pendV ? {pendOp, pendX, pendY} : 40'h0);
            if (rsp0_valid || rsp1_valid) begin
               chk("rsp_single", rsp0_valid && rsp1_valid, 1'b0);
               if (q.size() == 0) chk("rsp_unexpected", 1, 0);
               else begin
                  it = q.pop_front();
                  chk("rsp_id", rsp1_valid, it.id);
                  chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, it.data);
                  chk("rsp_flags", rsp1_valid ? rsp1_flags : rsp0_flags, it.fl);
                  chk("rsp_cycle", cyc, it.due);
               end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
               chk("rsp_missing", 0, 1);
               void'(q.pop_front());
            end
            if (pendV) begin
               r = refAlu(pendOp, pendX, pendY, mF);
               q.push_back('{pendId, r[15:0], r[19:16], cyc + 1});
               mF = flags_wr_en ? flags_wr_data : ((mF & ~pendM) | (r[19:16] & pendM));
            end else if (flags_wr_en) mF = flags_wr_data;
            acc0 = req0_valid && e0;
            acc1 = req1_valid && e1;
            pendV = acc0 || acc1;
            pendId = acc1;
            pendOp = acc1 ? req1_op : req0_op;
            pendX = acc1 ? req1_x : req0_x;
            pendY = acc1 ? req1_y : req0_y;
            pendM = acc1 ? req1_fmask : req0_fmask;
            if (pendV) begin
               mLast = acc1;
               mIdle = 0;
               mOwner = (acc1 ? req1_lock : req0_lock) ? (acc1 ? 2 : 1) : 0;
            end else if (mOwner != 0) begin
               if (eDrop) begin mOwner = 0; mIdle = 0; end
               else mIdle++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int n, input logic [7:0] op, input logic [15:0] x, input logic [15:0] y, input logic [3:0] m, input logic lk);
      if (n == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y; req0_fmask = m; req0_lock = lk;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y; req1_fmask = m; req1_lock = lk;
      end
   endtask

   initial begin
      req0_valid = 0; req0_op = 0; req0_x = 0; req0_y = 0; req0_fmask = 0; req0_lock = 0;
      req1_valid = 0; req1_op = 0; req1_x = 0; req1_y = 0; req1_fmask = 0; req1_lock = 0;
      flags_wr_en = 0; flags_wr_data = 0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      // ADD with F=0
      flags_wr_en = 1'b1; flags_wr_data = 4'h0;
      step();
      flags_wr_en = 1'b0;
      setReq(0, 8'h00, 16'h003A, 16'h00C6, 4'hF, 1'b0);
      #1 chk("add_ready", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      step();
      chk("add_rsp_valid", rsp0_valid, 1'b1);
      chk("add_rsp_data", rsp0_data, 16'h0100);
      chk("add_rsp_flags", rsp0_flags, 4'b1011);
      chk("add_F", flags, 4'hB);
      // reset during execute: op discarded
      flags_wr_en = 1'b1; flags_wr_data = 4'h2;
      setReq(0, 8'h02, 16'h1234, 16'h0034, 4'hF, 1'b0);
      step();
      flags_wr_en = 1'b0; req0_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_flags", flags, 4'hB);
      chk("rst_mid_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
      step(); step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("rst_no_stale", {rsp0_valid, rsp1_valid}, 2'b00);
      // round robin with both valid
      for (int i = 0; i < 8; i++) begin
         setReq(0, 8'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 1'b0);
         setReq(1, 8'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 1'b0);
         #1 chk("rr_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
         step();
      end
      req0_valid = 0; req1_valid = 0;
      repeat (3) step();
      // locked chain ADD -> gap -> DAA while req1 waits
      setReq(0, 8'h00, 16'h0019, 16'h0028, 4'hF, 1'b1);
      setReq(1, 8'h02, 16'h0050, 16'h0010, 4'hF, 1'b0);
      #1 chk("lk_add_ready", {req1_ready, req0_ready}, 2'b01);
      step();
      req0_valid = 1'b0;
      #1 chk("lk_gap_r1", req1_ready, 1'b0);
      chk("lk_owner", lock_owner, 2'b01);
      step();
      setReq(0, 8'h01, 16'h0041, 16'h0000, 4'hF, 1'b0);
      #1 chk("lk_daa_ready", {req1_ready, req0_ready}, 2'b01);
      step();
      req0_valid = 1'b0;
      #1 chk("lk_r1_after", req1_ready, 1'b1);
      chk("lk_released", lock_owner, 2'b00);
      step();
      req1_valid = 1'b0;
      repeat (3) step();
      // lock timeout
      setReq(0, 8'h03, 16'hFFFF, 16'h0007, 4'h1, 1'b1);
      setReq(1, 8'h00, 16'h0001, 16'h0002, 4'hF, 1'b0);
      #1 chk("to_lock_ready", {req1_ready, req0_ready}, 2'b01);
      step();
      req0_valid = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         #1 chk("to_drop", lock_drop, k == TO);
         chk("to_r1_blocked", req1_ready, 1'b0);
         chk("to_owner", lock_owner, 2'b01);
         step();
      end
      #1 chk("to_owner_clear", lock_owner, 2'b00);
      chk("to_r1_ready", req1_ready, 1'b1);
      chk("to_drop_once", lock_drop, 1'b0);
      step();
      req1_valid = 1'b0;
      repeat (3) step();
      // fmask and direct write
      flags_wr_en = 1'b1; flags_wr_data = 4'h0;
      step();
      flags_wr_en = 1'b0;
      setReq(0, 8'h03, 16'hFFFF, 16'h000E, 4'b0001, 1'b0);
      step();
      req0_valid = 1'b0;
      step();
      chk("mask_F", flags, 4'h0);
      chk("mask_rsp_flags", rsp0_flags, 4'b1110);
      setReq(0, 8'h03, 16'hFFFF, 16'h000E, 4'b0001, 1'b0);
      step();
      req0_valid = 1'b0; flags_wr_en = 1'b1; flags_wr_data = 4'h5;
      step();
      flags_wr_en = 1'b0;
      chk("wr_F", flags, 4'h5);
      chk("wr_rsp_flags", rsp0_flags, 4'b1110);
      chk("wr_rsp_valid", rsp0_valid, 1'b1);
      // random traffic
      for (int i = 0; i < 800; i++) begin
         req0_valid = ($urandom_range(0, 9) < 6); req1_valid = ($urandom_range(0, 9) < 6);
         req0_op = 8'($urandom); req0_x = 16'($urandom); req0_y = 16'($urandom);
         req0_fmask = 4'($urandom); req0_lock = ($urandom_range(0, 9) < 3);
         req1_op = 8'($urandom); req1_x = 16'($urandom); req1_y = 16'($urandom);
         req1_fmask = 4'($urandom); req1_lock = ($urandom_range(0, 9) < 3);
         flags_wr_en = ($urandom_range(0, 19) == 0); flags_wr_data = 4'($urandom);
         if (i % 200 == 150) begin
            req0_valid = 0; req1_valid = 0;
            repeat (20) step();
         end
         step();
      end
      req0_valid = 0; req1_valid = 0; flags_wr_en = 0;
      repeat (24) step();
      chk("sb_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
